ram_arbiter: RTL and testbench

Shared backing-memory responder on the far side of the cache-to-RAM port. It arbitrates `CLIENTS` cache instances that each drive `ram_read`/`ram_write`/`ram_addr`/`ram_data_in` and wait on `grant`. It issues one grant at a time for a whole burst and services the granted client from an internal synchronous single-port RAM of `2**ADDR_WIDTH` words. Read data returns one cycle after the accepted read request.

---
 rtl/ram_arbiter.sv | 155 +++++++++++++++
 tb/tb_ram_arbiter.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_arbiter.sv
// Burst arbiter in front of a synchronous single-port RAM shared by CLIENTS caches.
// Define RAM_ARBITER_RR_EN for round-robin selection; otherwise fixed priority (lowest index wins).
module ram_arbiter #(
   parameter int CLIENTS    = 2,
   parameter int ADDR_WIDTH = 14,
   parameter int DATA_WIDTH = 10,
   parameter int MAX_BURST  = 64,
   parameter int CW         = (CLIENTS > 1) ? $clog2(CLIENTS) : 1
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic [CLIENTS-1:0]               cl_read,
   input  logic [CLIENTS-1:0]               cl_write,
   input  logic [CLIENTS*ADDR_WIDTH-1:0]    cl_addr,
   input  logic [CLIENTS*DATA_WIDTH-1:0]    cl_wdata,
   output logic [CLIENTS-1:0]               grant,
   output logic [DATA_WIDTH-1:0]            rdata,
   output logic [CW-1:0]                    owner,
   output logic                             busy,
   output logic                             burst_err,
   input  logic                             err_clr
);

   localparam int BW = $clog2(MAX_BURST) + 1;

   typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

   // Handshake: a client raises cl_read or cl_write with a stable address and data and
   // keeps it high for the whole burst. While grant[i] is high, every rising edge on
   // which client i still requests performs its access (write wins over read; read
   // data appears on rdata after that edge). The client ends the burst by dropping
   // both requests; grant stays high through that cycle and falls on the next edge.

   state_t                  state, state_d;
   logic [CLIENTS-1:0]      req;
   logic [CLIENTS-1:0]      grant_d;
   logic [CW-1:0]           owner_d;
   logic [CW-1:0]           win_idx;
   logic                    win_found;
   logic [BW-1:0]           burst_cnt, cnt_d;
   logic                    err_set;
   logic                    own_req;
   logic                    mem_we, mem_re;
   logic [ADDR_WIDTH-1:0]   own_addr;
   logic [DATA_WIDTH-1:0]   own_wdata;
   int                      start_idx;

   logic [DATA_WIDTH-1:0]   mem [0:(2**ADDR_WIDTH)-1];

   assign req       = cl_read | cl_write;
   assign own_req   = req[owner];
   assign own_addr  = cl_addr[int'(owner)*ADDR_WIDTH +: ADDR_WIDTH];
   assign own_wdata = cl_wdata[int'(owner)*DATA_WIDTH +: DATA_WIDTH];

`ifdef RAM_ARBITER_RR_EN
   // rr_ptr holds last_owner+1, so the search begins just past the previous grantee.
   logic [CW-1:0] rr_ptr;
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         rr_ptr <= '0;
      else if (state == IDLE && win_found)
         rr_ptr <= CW'((int'(win_idx) + 1) % CLIENTS);
   end
   assign start_idx = int'(rr_ptr);
`else
   assign start_idx = 0;
`endif

   always_comb begin
      logic [CW-1:0] j;
      win_found = 1'b0;
      win_idx   = '0;
      j         = '0;
      for (int i = 0; i < CLIENTS; i++) begin
         j = CW'((start_idx + i) % CLIENTS);
         if (!win_found && req[j]) begin
            win_found = 1'b1;
            win_idx   = j;
         end
      end
   end

   // State register and the registered outputs that travel with it.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         grant     <= '0;
         owner     <= '0;
         burst_cnt <= '0;
         burst_err <= 1'b0;
         rdata     <= '0;
      end else begin
         state     <= state_d;
         grant     <= grant_d;
         owner     <= owner_d;
         burst_cnt <= cnt_d;
         if (err_set)
            burst_err <= 1'b1;
         else if (err_clr)
            burst_err <= 1'b0;
         if (mem_re)
            rdata <= mem[own_addr];
      end
   end

   // Next-state logic.
   always_comb begin
      state_d = state;
      grant_d = grant;
      owner_d = owner;
      cnt_d   = burst_cnt;
      err_set = 1'b0;
      case (state)
         IDLE: begin
            grant_d = '0;
            if (win_found) begin
               owner_d          = win_idx;
               grant_d[win_idx] = 1'b1;
               cnt_d            = '0;
               state_d          = BUSY;
            end
         end
         BUSY: begin
            if (burst_cnt != {BW{1'b1}})
               cnt_d = burst_cnt + 1'b1;
            if (!own_req) begin
               grant_d = '0;
               state_d = IDLE;
            end else if (burst_cnt == BW'(MAX_BURST - 1)) begin
               grant_d = '0;
               err_set = 1'b1;
               state_d = IDLE;
            end
         end
         default: begin
            grant_d = '0;
            state_d = IDLE;
         end
      endcase
   end

   // Output decode; busy doubles as the externally visible FSM state.
   always_comb begin
      busy   = (state == BUSY);
      mem_we = (state == BUSY) && cl_write[owner];
      mem_re = (state == BUSY) && cl_read[owner] && !cl_write[owner];
   end

   // RAM array has no reset so its contents survive rst.
   always_ff @(posedge clk) begin
      if (mem_we)
         mem[own_addr] <= own_wdata;
   end

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed self-checking bench for ram_arbiter (two clients, default parameters).
module tb_ram_arbiter;

   localparam int AW = 14;
   localparam int DW = 10;
   localparam int NC = 2;

   logic              clk = 1'b0;
   logic              rst;
   logic [NC-1:0]     cl_read, cl_write;
   logic [NC*AW-1:0]  cl_addr;
   logic [NC*DW-1:0]  cl_wdata;
   logic [NC-1:0]     grant;
   logic [DW-1:0]     rdata;
   logic [0:0]        owner;
   logic              busy, burst_err, err_clr;

   int errors = 0;
   int checks = 0;
   logic [DW-1:0] got_q [$];
   int            busy_cycles;
   logic [NC-1:0] first_grant;
   logic          drop_grant;

   ram_arbiter dut (
      .clk(clk), .rst(rst), .cl_read(cl_read), .cl_write(cl_write),
      .cl_addr(cl_addr), .cl_wdata(cl_wdata), .grant(grant), .rdata(rdata),
      .owner(owner), .busy(busy), .burst_err(burst_err), .err_clr(err_clr)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL global_timeout");
      $fatal(1, "timeout");
   end

   task automatic set_client(input int c, input logic rd, input logic wr,
                             input logic [AW-1:0] a, input logic [DW-1:0] d);
      cl_read[c]            = rd;
      cl_write[c]           = wr;
      cl_addr[c*AW +: AW]   = a;
      cl_wdata[c*DW +: DW]  = d;
   endtask

   // Drives one burst of n accesses from client c; data_is_addr writes addr[9:0].
   task automatic run_burst(input int c, input logic rd, input logic wr,
                            input logic [AW-1:0] base, input int n,
                            input logic data_is_addr, input logic [DW-1:0] wd,
                            output int lat);
      logic [AW-1:0] a;
      got_q.delete();
      busy_cycles = 0;
      a = base;
      set_client(c, rd, wr, a, data_is_addr ? a[DW-1:0] : wd);
      lat = -1;
      for (int t = 1; t <= 20; t++) begin
         @(negedge clk);
         if (grant[c]) begin
            lat = t;
            break;
         end
      end
      first_grant = grant;
      if (lat < 0) begin
         set_client(c, 1'b0, 1'b0, '0, '0);
         return;
      end
      busy_cycles = 1;
      for (int k = 0; k < n; k++) begin
         a = AW'(int'(base) + k);
         set_client(c, rd, wr, a, data_is_addr ? a[DW-1:0] : wd);
         @(negedge clk);
         got_q.push_back(rdata);
         if (busy) busy_cycles++;
      end
      set_client(c, 1'b0, 1'b0, a, '0);
      drop_grant = grant[c];
      @(negedge clk);
      if (busy) busy_cycles++;
   endtask

   task automatic test_reset;
      rst = 1'b1; err_clr = 1'b0;
      cl_read = '0; cl_write = '0; cl_addr = '0; cl_wdata = '0;
      repeat (3) @(negedge clk);
      checks++; if (grant !== 2'b00) begin errors++; $display("FAIL reset_grant got=%b exp=00", grant); end
      checks++; if (rdata !== 10'h000) begin errors++; $display("FAIL reset_rdata got=%h exp=000", rdata); end
      checks++; if (owner !== 1'b0) begin errors++; $display("FAIL reset_owner got=%b exp=0", owner); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
      checks++; if (burst_err !== 1'b0) begin errors++; $display("FAIL reset_err got=%b exp=0", burst_err); end
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_single_burst;
      int lat;
      run_burst(0, 1'b0, 1'b1, 14'h0040, 32, 1'b1, '0, lat);
      checks++; if (lat !== 1) begin errors++; $display("FAIL wr_grant_latency got=%0d exp=1", lat); end
      checks++; if (first_grant !== 2'b01) begin errors++; $display("FAIL wr_grant_value got=%b exp=01", first_grant); end
      checks++; if (grant !== 2'b00 || busy !== 1'b0) begin errors++; $display("FAIL wr_release got=%b/%b exp=00/0", grant, busy); end
      run_burst(0, 1'b1, 1'b0, 14'h0040, 32, 1'b0, '0, lat);
      checks++; if (lat !== 1) begin errors++; $display("FAIL rd_grant_latency got=%0d exp=1", lat); end
      for (int k = 0; k < 32; k++) begin
         checks++;
         if (got_q[k] !== 10'(10'h040 + k)) begin
            errors++; $display("FAIL rd_word%0d got=%h exp=%h", k, got_q[k], 10'(10'h040 + k));
         end
      end
      checks++; if (drop_grant !== 1'b1) begin errors++; $display("FAIL rd_drop_grant got=%b exp=1", drop_grant); end
      checks++; if (busy_cycles !== 33) begin errors++; $display("FAIL rd_busy_cycles got=%0d exp=33", busy_cycles); end
      checks++; if (grant !== 2'b00) begin errors++; $display("FAIL rd_release got=%b exp=00", grant); end
      @(negedge clk);
      checks++; if (rdata !== 10'h05F) begin errors++; $display("FAIL rdata_hold_idle got=%h exp=05F", rdata); end
   endtask

   task automatic test_back_to_back;
      logic [NC-1:0] exp_g [4];
      int own;
`ifdef RAM_ARBITER_RR_EN
      exp_g = '{2'b01, 2'b10, 2'b01, 2'b10};
`else
      exp_g = '{2'b01, 2'b01, 2'b01, 2'b01};
`endif
      rst = 1'b1; @(negedge clk); rst = 1'b0;
      set_client(0, 1'b1, 1'b0, 14'h0041, '0);
      set_client(1, 1'b1, 1'b0, 14'h0042, '0);
      @(negedge clk);
      for (int g = 0; g < 4; g++) begin
         checks++; if (grant !== exp_g[g]) begin errors++; $display("FAIL b2b_grant%0d got=%b exp=%b", g, grant, exp_g[g]); end
         own = (exp_g[g] == 2'b10) ? 1 : 0;
         checks++; if (owner !== 1'(own)) begin errors++; $display("FAIL b2b_owner%0d got=%b exp=%0d", g, owner, own); end
         repeat (2) @(negedge clk);
         cl_read[own] = 1'b0;
         @(negedge clk);
         checks++; if (grant !== 2'b00) begin errors++; $display("FAIL b2b_idle%0d got=%b exp=00", g, grant); end
         cl_read[own] = 1'b1;
         @(negedge clk);
      end
      cl_read = '0;
      repeat (3) @(negedge clk);
   endtask

   task automatic test_rw_both;
      int lat;
      run_burst(0, 1'b1, 1'b0, 14'h0040, 1, 1'b0, '0, lat);
      checks++; if (got_q[0] !== 10'h040) begin errors++; $display("FAIL rw_pre_read got=%h exp=040", got_q[0]); end
      run_burst(0, 1'b1, 1'b1, 14'h0100, 1, 1'b0, 10'h3AA, lat);
      checks++; if (rdata !== 10'h040) begin errors++; $display("FAIL rw_rdata_hold got=%h exp=040", rdata); end
      run_burst(0, 1'b1, 1'b0, 14'h0100, 1, 1'b0, '0, lat);
      checks++; if (got_q[0] !== 10'h3AA) begin errors++; $display("FAIL rw_readback got=%h exp=3AA", got_q[0]); end
   endtask

   task automatic test_ungranted_write;
      int lat;
      run_burst(0, 1'b0, 1'b1, 14'h0200, 1, 1'b0, 10'h0AB, lat);
      set_client(0, 1'b1, 1'b0, 14'h0040, '0);
      @(negedge clk);
      checks++; if (grant !== 2'b01) begin errors++; $display("FAIL ug_owner_grant got=%b exp=01", grant); end
      set_client(1, 1'b0, 1'b1, 14'h0200, 10'h155);
      repeat (4) @(negedge clk);
      set_client(1, 1'b0, 1'b0, '0, '0);
      set_client(0, 1'b0, 1'b0, '0, '0);
      repeat (2) @(negedge clk);
      run_burst(1, 1'b1, 1'b0, 14'h0200, 1, 1'b0, '0, lat);
      checks++; if (first_grant !== 2'b10) begin errors++; $display("FAIL ug_c1_grant got=%b exp=10", first_grant); end
      checks++; if (owner !== 1'b1) begin errors++; $display("FAIL ug_c1_owner got=%b exp=1", owner); end
      checks++; if (got_q[0] !== 10'h0AB) begin errors++; $display("FAIL ug_dropped_write got=%h exp=0AB", got_q[0]); end
      run_burst(1, 1'b1, 1'b0, 14'h0040, 1, 1'b0, '0, lat);
      checks++; if (got_q[0] !== 10'h040) begin errors++; $display("FAIL ug_owner_addr got=%h exp=040", got_q[0]); end
   endtask

   task automatic test_watchdog;
      int n_busy, rel_at;
      logic g_rel, e_rel;
      n_busy = 0; rel_at = -1; g_rel = 1'b1; e_rel = 1'b0;
      set_client(0, 1'b1, 1'b0, 14'h0040, '0);
      for (int t = 1; t <= 100; t++) begin
         @(negedge clk);
         if (rel_at < 0) begin
            if (busy) n_busy++;
            else if (n_busy > 0) begin
               rel_at = t; g_rel = grant[0]; e_rel = burst_err;
            end
         end
      end
      checks++; if (n_busy !== 64) begin errors++; $display("FAIL wd_busy_cycles got=%0d exp=64", n_busy); end
      checks++; if (rel_at !== 65) begin errors++; $display("FAIL wd_release_at got=%0d exp=65", rel_at); end
      checks++; if (g_rel !== 1'b0 || e_rel !== 1'b1) begin errors++; $display("FAIL wd_release_state got=%b/%b exp=0/1", g_rel, e_rel); end
      set_client(0, 1'b0, 1'b0, '0, '0);
      for (int t = 0; t < 10 && busy; t++) @(negedge clk);
      @(negedge clk);
      checks++; if (burst_err !== 1'b1) begin errors++; $display("FAIL wd_sticky got=%b exp=1", burst_err); end
      err_clr = 1'b1; @(negedge clk); err_clr = 1'b0;
      checks++; if (burst_err !== 1'b0) begin errors++; $display("FAIL wd_clear got=%b exp=0", burst_err); end
      set_client(0, 1'b1, 1'b0, 14'h0040, '0);
      repeat (64) @(negedge clk);
      checks++; if (busy !== 1'b1 || burst_err !== 1'b0) begin errors++; $display("FAIL wd_pre_set got=%b/%b exp=1/0", busy, burst_err); end
      err_clr = 1'b1;
      @(negedge clk);
      err_clr = 1'b0;
      set_client(0, 1'b0, 1'b0, '0, '0);
      checks++; if (burst_err !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL wd_set_wins got=%b/%b exp=1/0", burst_err, busy); end
      repeat (2) @(negedge clk);
      err_clr = 1'b1; @(negedge clk); err_clr = 1'b0;
   endtask

   task automatic test_reset_mid_burst;
      int lat;
      logic [AW-1:0] a;
      run_burst(0, 1'b0, 1'b1, 14'h0304, 1, 1'b0, 10'h1C3, lat);
      a = 14'h0300;
      set_client(0, 1'b0, 1'b1, a, a[DW-1:0]);
      for (int t = 0; t < 20 && !grant[0]; t++) @(negedge clk);
      for (int k = 0; k < 4; k++) begin
         a = AW'(14'h0300 + k);
         set_client(0, 1'b0, 1'b1, a, a[DW-1:0]);
         @(negedge clk);
      end
      set_client(0, 1'b0, 1'b1, 14'h0304, 10'h2EE);
      rst = 1'b1;
      #1;
      checks++; if (grant !== 2'b00 || busy !== 1'b0) begin errors++; $display("FAIL rst_async got=%b/%b exp=00/0", grant, busy); end
      @(posedge clk);
      #1;
      set_client(0, 1'b0, 1'b0, '0, '0);
      @(negedge clk);
      rst = 1'b0;
      checks++; if (rdata !== 10'h000) begin errors++; $display("FAIL rst_rdata got=%h exp=000", rdata); end
      @(negedge clk);
      run_burst(0, 1'b1, 1'b0, 14'h0300, 5, 1'b0, '0, lat);
      for (int k = 0; k < 4; k++) begin
         checks++;
         if (got_q[k] !== 10'(10'h300 + k)) begin
            errors++; $display("FAIL rst_keep%0d got=%h exp=%h", k, got_q[k], 10'(10'h300 + k));
         end
      end
      checks++; if (got_q[4] !== 10'h1C3) begin errors++; $display("FAIL rst_inflight_write got=%h exp=1C3", got_q[4]); end
   endtask

   initial begin
      test_reset();
      test_single_burst();
      test_back_to_back();
      test_rw_both();
      test_ungranted_write();
      test_watchdog();
      test_reset_mid_burst();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
